instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/legv8_pkg.sv | 42 ++++
 rtl/leg_field_pack.sv | 49 ++++
 rtl/instr_encoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// LEGv8 encoding constants shared by the program encoder and Main_Control decoding:
// op codes, format opcodes, field widths and FSM states.
package legv8_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOrr  = 4'd3,
        OpLdur = 4'd4,
        OpStur = 4'd5,
        OpCbz  = 4'd6,
        OpB    = 4'd7,
        OpMovk = 4'd8
    } op_e;

    localparam logic [10:0] OpcAdd  = 11'b10001011000;
    localparam logic [10:0] OpcSub  = 11'b11001011000;
    localparam logic [10:0] OpcAnd  = 11'b10001010000;
    localparam logic [10:0] OpcOrr  = 11'b10101010000;
    localparam logic [10:0] OpcLdur = 11'b11111000010;
    localparam logic [10:0] OpcStur = 11'b11111000000;
    localparam logic [7:0]  OpcCbz  = 8'b10110100;
    localparam logic [5:0]  OpcB    = 6'b000101;
    localparam logic [8:0]  OpcMovk = 9'b111100101;

    localparam int unsigned OpW    = 4;
    localparam int unsigned RegW   = 5;
    localparam int unsigned ImmW   = 26;
    localparam int unsigned DtImmW = 9;
    localparam int unsigned CbImmW = 19;
    localparam int unsigned BImmW  = 26;
    localparam int unsigned IwImmW = 16;
    localparam int unsigned AddrW  = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/leg_field_pack.sv
// Combinational LEGv8 field packer: op plus fields in, 32-bit word and drop flags out.
// ENC_RANGE_CHECK_EN enables immediate range checking; otherwise immediates are truncated.
module leg_field_pack
    import legv8_pkg::*;
(
    input  logic [OpW-1:0]  op,
    input  logic [RegW-1:0] rd,
    input  logic [RegW-1:0] rn,
    input  logic [RegW-1:0] rm,
    input  logic [ImmW-1:0] imm,
    input  logic [1:0]      hw,
    output logic [31:0]     word,
    output logic            illegal,
    output logic            range_fail
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_e'(op))
            OpAdd:   word = {OpcAdd, rm, 6'b000000, rn, rd};
            OpSub:   word = {OpcSub, rm, 6'b000000, rn, rd};
            OpAnd:   word = {OpcAnd, rm, 6'b000000, rn, rd};
            OpOrr:   word = {OpcOrr, rm, 6'b000000, rn, rd};
            OpLdur:  word = {OpcLdur, imm[DtImmW-1:0], 2'b00, rn, rd};
            OpStur:  word = {OpcStur, imm[DtImmW-1:0], 2'b00, rn, rd};
            OpCbz:   word = {OpcCbz, imm[CbImmW-1:0], rd};
            OpB:     word = {OpcB, imm[BImmW-1:0]};
            OpMovk:  word = {OpcMovk, hw, imm[IwImmW-1:0], rd};
            default: illegal = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Signed fields fit when every bit above the field's sign bit matches it.
    always_comb begin
        range_fail = 1'b0;
        case (op_e'(op))
            OpLdur, OpStur: range_fail = !((&imm[ImmW-1:DtImmW-1]) || !(|imm[ImmW-1:DtImmW-1]));
            OpCbz:          range_fail = !((&imm[ImmW-1:CbImmW-1]) || !(|imm[ImmW-1:CbImmW-1]));
            OpMovk:         range_fail = |imm[ImmW-1:IwImmW];
            default:        range_fail = 1'b0;
        endcase
    end
`else
    assign range_fail = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams LEGv8 requests into encoded words with byte addresses for an instruction-memory writer.
// Range checking of immediates is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
    import legv8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OpW-1:0]   in_op,
    input  logic [RegW-1:0]  in_rd,
    input  logic [RegW-1:0]  in_rn,
    input  logic [RegW-1:0]  in_rm,
    input  logic [ImmW-1:0]  in_imm,
    input  logic [1:0]       in_hw,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [AddrW-1:0] out_addr,
    output logic             err,
    output logic             ovf,
    output logic             done
);

    state_e           state_q, state_d;
    logic             out_valid_q;
    logic [31:0]      out_instr_q;
    logic [AddrW-1:0] addr_q;
    logic             out_last_q;
    logic             err_q;
    logic             ovf_q;
    logic             last_drop_q;

    logic [31:0] word;
    logic        illegal;
    logic        range_fail;
    logic        accept, drop, take, hs;

    leg_field_pack u_pack (
        .op         (in_op),
        .rd         (in_rd),
        .rn         (in_rn),
        .rm         (in_rm),
        .imm        (in_imm),
        .hw         (in_hw),
        .word       (word),
        .illegal    (illegal),
        .range_fail (range_fail)
    );

    assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drop     = accept && (illegal || range_fail);
    assign take     = accept && !drop;
    assign hs       = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StRun;
            // A dropped last request still ends the program, one cycle after the drop.
            StRun:  if ((hs && out_last_q) || last_drop_q) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            addr_q      <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            last_drop_q <= 1'b0;
        end else begin
            err_q       <= drop;
            last_drop_q <= drop && in_last;

            // addr_q is the address of the held word, or of the next word when none is held.
            if (state_q == StIdle && start) begin
                addr_q <= '0;
                ovf_q  <= 1'b0;
            end else if (hs) begin
                addr_q <= addr_q + AddrW'(4);
                if (addr_q == AddrW'(1020)) ovf_q <= 1'b1;
            end

            if (take) begin
                out_valid_q <= 1'b1;
                out_instr_q <= word;
                out_last_q  <= in_last;
            end else if (hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign ovf       = ovf_q;
    assign done      = (state_q == StDone);

endmodule
